// File: rtl/bus_slave_if_pkg.sv
// bus_slave_if_pkg: state encoding and bus constants shared by the bus slave interface.
package bus_slave_if_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, DEV, RESP} bus_slv_state_e;

    localparam logic [31:0] BUS_SLV_ERR_DATA = 32'hDEAD_BEEF;

    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;
    localparam logic READ     = 1'b1;
    localparam logic WRITE    = 1'b0;

endpackage

// File: rtl/bus_slave_if.sv
// bus_slave_if: bus target that forwards one strobed transfer to a local device port,
// with fixed wait states, device handshake and a watchdog that forces completion.
module bus_slave_if
    import bus_slave_if_pkg::*;
#(
    parameter int          ADDR_W      = 8,
    parameter int          WAIT_CYCLES = 0,
    parameter int          TIMEOUT     = 64,
    parameter logic [31:0] ERR_DATA    = BUS_SLV_ERR_DATA
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bus_cs_,
    input  logic              bus_as_,
    input  logic              bus_rw,
    input  logic [29:0]       bus_addr,
    input  logic [31:0]       bus_wr_data,
    output logic [31:0]       bus_rd_data,
    output logic              bus_rdy_,
    output logic              dev_req,
    output logic [ADDR_W-1:0] dev_addr,
    output logic              dev_rw,
    output logic [31:0]       dev_wr_data,
    input  logic [31:0]       dev_rd_data,
    input  logic              dev_ack,
    output logic              timeout_err
);

    localparam int TMO_W = $clog2(TIMEOUT) + 1;

    bus_slv_state_e    r_state, w_state;
    logic [3:0]        r_cnt, w_cnt;
    logic [TMO_W-1:0]  r_tmo, w_tmo;
    logic              r_req, w_req;
    logic [ADDR_W-1:0] r_addr, w_addr;
    logic              r_rw, w_rw;
    logic [31:0]       r_wd, w_wd;
    logic [31:0]       r_rd_buf, w_rd_buf;
    logic              r_rdy_, w_rdy_;
    logic [31:0]       r_rdata, w_rdata;
    logic              r_terr, w_terr;
    logic              w_unused;

    assign w_unused = ^bus_addr[29:ADDR_W];

    always_comb begin
        w_state  = r_state;
        w_cnt    = r_cnt;
        w_tmo    = r_tmo;
        w_req    = r_req;
        w_addr   = r_addr;
        w_rw     = r_rw;
        w_wd     = r_wd;
        w_rd_buf = r_rd_buf;
        w_rdy_   = DISABLE_;
        w_rdata  = '0;
        w_terr   = 1'b0;
        case (r_state)
            IDLE: if (!bus_cs_ && !bus_as_) begin
                w_addr  = bus_addr[ADDR_W-1:0];
                w_rw    = bus_rw;
                w_wd    = bus_wr_data;
                w_tmo   = '0;
                w_req   = (WAIT_CYCLES == 0);
                w_state = (WAIT_CYCLES == 0) ? DEV : WAIT;
                w_cnt   = 4'(WAIT_CYCLES - 1);
            end
            WAIT: begin
                w_cnt   = r_cnt - 4'd1;
                w_req   = (r_cnt == 4'd0);
                w_state = (r_cnt == 4'd0) ? DEV : WAIT;
            end
            DEV: begin
                w_tmo = r_tmo + 1'b1;
                // ack has priority over watchdog expiry in the same cycle
                if (dev_ack) begin
                    w_req    = 1'b0;
                    w_rd_buf = (r_rw == READ) ? dev_rd_data : r_rd_buf;
                    w_rdy_   = ENABLE_;
                    w_rdata  = (r_rw == READ) ? dev_rd_data : '0;
                    w_state  = RESP;
                end else if (r_tmo == TMO_W'(TIMEOUT - 1)) begin
                    w_req    = 1'b0;
                    w_rd_buf = ERR_DATA;
                    w_rdy_   = ENABLE_;
                    w_rdata  = (r_rw == READ) ? ERR_DATA : '0;
                    w_terr   = 1'b1;
                    w_state  = RESP;
                end
            end
            RESP: w_state = IDLE;
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_tmo    <= '0;
            r_req    <= 1'b0;
            r_addr   <= '0;
            r_rw     <= READ;
            r_wd     <= '0;
            r_rd_buf <= '0;
            r_rdy_   <= DISABLE_;
            r_rdata  <= '0;
            r_terr   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_cnt    <= w_cnt;
            r_tmo    <= w_tmo;
            r_req    <= w_req;
            r_addr   <= w_addr;
            r_rw     <= w_rw;
            r_wd     <= w_wd;
            r_rd_buf <= w_rd_buf;
            r_rdy_   <= w_rdy_;
            r_rdata  <= w_rdata;
            r_terr   <= w_terr;
        end
    end

    assign bus_rd_data = r_rdata;
    assign bus_rdy_    = r_rdy_;
    assign dev_req     = r_req;
    assign dev_addr    = r_addr;
    assign dev_rw      = r_rw;
    assign dev_wr_data = r_wd;
    assign timeout_err = r_terr;

endmodule

// File: tb/tb_bus_slave_if.sv
// tb_bus_slave_if: directed checks of two bus_slave_if instances
// (u0: no wait states, TIMEOUT=4; u3: three wait states, default watchdog).
module tb_bus_slave_if;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cs0_ = 1'b1, cs3_ = 1'b1, as_ = 1'b1, rw = 1'b1;
    logic [29:0] addr = '0;
    logic [31:0] wd = '0, drd = '0;
    logic        ack = 1'b0;

    logic [31:0] rd0, rd3, dwd0, dwd3;
    logic        rdy0_, rdy3_, req0, req3, drw0, drw3, terr0, terr3;
    logic [7:0]  dad0, dad3;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    bus_slave_if #(.ADDR_W(8), .WAIT_CYCLES(0), .TIMEOUT(4)) u0 (
        .clk(clk), .reset(reset), .bus_cs_(cs0_), .bus_as_(as_), .bus_rw(rw),
        .bus_addr(addr), .bus_wr_data(wd), .bus_rd_data(rd0), .bus_rdy_(rdy0_),
        .dev_req(req0), .dev_addr(dad0), .dev_rw(drw0), .dev_wr_data(dwd0),
        .dev_rd_data(drd), .dev_ack(ack), .timeout_err(terr0)
    );

    bus_slave_if #(.ADDR_W(8), .WAIT_CYCLES(3)) u3 (
        .clk(clk), .reset(reset), .bus_cs_(cs3_), .bus_as_(as_), .bus_rw(rw),
        .bus_addr(addr), .bus_wr_data(wd), .bus_rd_data(rd3), .bus_rdy_(rdy3_),
        .dev_req(req3), .dev_addr(dad3), .dev_rw(drw3), .dev_wr_data(dwd3),
        .dev_rd_data(drd), .dev_ack(ack), .timeout_err(terr3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic c0_, input logic c3_, input logic [29:0] a,
                          input logic r, input logic [31:0] d);
        cs0_ = c0_; cs3_ = c3_; as_ = 1'b0; addr = a; rw = r; wd = d;
        tick();
        cs0_ = 1'b1; cs3_ = 1'b1; as_ = 1'b1;
    endtask

    initial begin
        tick(); tick();
        reset = 1'b0;
        check("rst_rdy", 32'(rdy0_), 32'd1);
        check("rst_rd", rd0, 32'd0);
        check("rst_req", 32'(req0), 32'd0);
        check("rst_rw", 32'(drw0), 32'd1);
        check("rst_terr", 32'(terr0), 32'd0);
        check("rst_addr", 32'(dad0), 32'd0);
        // read, zero wait states, ack on first dev_req cycle
        strobe(1'b0, 1'b1, 30'h10, 1'b1, 32'h0);
        check("rd_req", 32'(req0), 32'd1);
        check("rd_addr", 32'(dad0), 32'h10);
        check("rd_rdy_early", 32'(rdy0_), 32'd1);
        ack = 1'b1; drd = 32'h1234_5678;
        tick();
        ack = 1'b0;
        check("rd_rdy", 32'(rdy0_), 32'd0);
        check("rd_data", rd0, 32'h1234_5678);
        check("rd_req_off", 32'(req0), 32'd0);
        tick();
        check("rd_rdy_off", 32'(rdy0_), 32'd1);
        check("rd_data_off", rd0, 32'd0);
        // timeout read, with an ignored strobe while in DEV
        tick();
        strobe(1'b0, 1'b1, 30'h20, 1'b1, 32'h0);
        check("to_req1", 32'(req0), 32'd1);
        tick();
        check("to_req2", 32'(req0), 32'd1);
        strobe(1'b0, 1'b1, 30'h30, 1'b0, 32'h9999_9999);
        check("to_req3", 32'(req0), 32'd1);
        check("to_addr_hold", 32'(dad0), 32'h20);
        check("to_rw_hold", 32'(drw0), 32'd1);
        tick();
        check("to_req4", 32'(req0), 32'd1);
        check("to_terr_early", 32'(terr0), 32'd0);
        tick();
        check("to_req_off", 32'(req0), 32'd0);
        check("to_rdy", 32'(rdy0_), 32'd0);
        check("to_terr", 32'(terr0), 32'd1);
        check("to_data", rd0, 32'hDEAD_BEEF);
        tick();
        check("to_terr_off", 32'(terr0), 32'd0);
        check("to_rdy_off", 32'(rdy0_), 32'd1);
        check("to_state_idle", 32'(req0), 32'd0);
        // ack coinciding with watchdog expiry
        strobe(1'b0, 1'b1, 30'h21, 1'b1, 32'h0);
        for (int i = 0; i < 3; i++) begin
            check("ax_req", 32'(req0), 32'd1);
            tick();
        end
        check("ax_req4", 32'(req0), 32'd1);
        ack = 1'b1; drd = 32'hCAFE_F00D;
        tick();
        ack = 1'b0;
        check("ax_rdy", 32'(rdy0_), 32'd0);
        check("ax_data", rd0, 32'hCAFE_F00D);
        check("ax_terr", 32'(terr0), 32'd0);
        tick();
        // back-to-back write accepted in the cycle after RESP
        strobe(1'b0, 1'b1, 30'h44, 1'b0, 32'h1111_2222);
        check("bb_req", 32'(req0), 32'd1);
        check("bb_rw", 32'(drw0), 32'd0);
        check("bb_wd", dwd0, 32'h1111_2222);
        check("bb_addr", 32'(dad0), 32'h44);
        ack = 1'b1; drd = 32'h7777_7777;
        tick();
        ack = 1'b0;
        check("bb_rdy", 32'(rdy0_), 32'd0);
        check("bb_data", rd0, 32'd0);
        tick();
        // strobe without chip select is ignored
        strobe(1'b1, 1'b1, 30'h55, 1'b1, 32'h0);
        check("nocs_req", 32'(req0), 32'd0);
        check("nocs_addr", 32'(dad0), 32'h44);
        tick();
        check("nocs_rdy", 32'(rdy0_), 32'd1);
        // write with three wait states
        strobe(1'b1, 1'b0, 30'h08, 1'b0, 32'hA5A5_A5A5);
        tick(); tick();
        check("w3_req_t3", 32'(req3), 32'd0);
        tick();
        check("w3_req_t4", 32'(req3), 32'd1);
        check("w3_rw", 32'(drw3), 32'd0);
        check("w3_wd", dwd3, 32'hA5A5_A5A5);
        tick();
        check("w3_req_t5", 32'(req3), 32'd1);
        tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("w3_rdy", 32'(rdy3_), 32'd0);
        check("w3_data", rd3, 32'd0);
        check("w3_terr", 32'(terr3), 32'd0);
        tick();
        check("w3_rdy_off", 32'(rdy3_), 32'd1);
        // reset during WAIT aborts with no ready
        strobe(1'b1, 1'b0, 30'h09, 1'b1, 32'h0);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rw_req", 32'(req3), 32'd0);
        check("rw_rdy", 32'(rdy3_), 32'd1);
        check("rw_addr", 32'(dad3), 32'd0);
        for (int i = 0; i < 8; i++) begin
            check("rw_norequest", 32'(req3), 32'd0);
            check("rw_nordy", 32'(rdy3_), 32'd1);
            tick();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bus_slave_if.md
Name: bus_slave_if

Overview:
Generic bus responder, the target-side counterpart of the CPU bus master interface on the shared AZPR bus. It accepts a one-cycle address strobe from the granted master and presents the transfer to a simple local device port. It inserts programmable wait states, waits for the device acknowledge, and returns a one-cycle ready with read data. A watchdog completes any transfer whose device never acknowledges, so the bus cannot hang.

Parameters:
ADDR_W, 8, number of low word-address bits forwarded to the device
WAIT_CYCLES, 0, fixed wait states inserted before dev_req (0..15)
TIMEOUT, 64, max cycles dev_req stays high before forced completion (>=1)
ERR_DATA, 32'hDEAD_BEEF, read data returned on timeout

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
bus_cs_  in  1  chip select from address decoder, active low
bus_as_  in  1  address strobe, active low, one-cycle pulse
bus_rw  in  1  READ=1 / WRITE=0 (stddef encoding)
bus_addr  in  30  word address, held by master until ready
bus_wr_data  in  32  write data
bus_rd_data  out  32  read data, valid only in the bus_rdy_ cycle, else 0
bus_rdy_  out  1  ready, active low, one-cycle pulse
dev_req  out  1  device request, level
dev_addr  out  ADDR_W  latched bus_addr[ADDR_W-1:0]
dev_rw  out  1  latched bus_rw
dev_wr_data  out  32  latched write data
dev_rd_data  in  32  device read data, valid with dev_ack
dev_ack  in  1  device acknowledge, active high
timeout_err  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- Reset (synchronous, active-high, priority over all): state=IDLE; bus_rdy_=DISABLE_ (1); bus_rd_data=0; dev_req=0; dev_addr, dev_rw=READ, dev_wr_data, rd_buf, counters=0; timeout_err=0. Reset during any state aborts the transfer with no rdy_.
- All outputs are registered.
- IDLE: when bus_cs_==0 and bus_as_==0, latch addr/rw/wr_data. If WAIT_CYCLES==0, go to DEV with dev_req=1; otherwise go to WAIT with cnt=WAIT_CYCLES-1. A strobe without cs_ is ignored.
- WAIT: cnt decrements. When cnt==0, go to DEV and set dev_req=1.
- DEV: dev_req held high; tmo counts cycles.
  - dev_ack=1: dev_req=0; if read, rd_buf=dev_rd_data; go to RESP. A same-cycle ack of the first dev_req cycle is legal.
  - Otherwise, if tmo==TIMEOUT-1: dev_req=0; rd_buf=ERR_DATA; timeout_err=1; go to RESP.
  - An ack in the same cycle as expiry wins, and no error is raised.
- RESP: exactly one cycle. bus_rdy_=0; bus_rd_data=rd_buf for reads, 0 for writes. Next cycle: rdy_=1, rd_data=0, state=IDLE.
- Latency: strobe at cycle T, dev_req at T+1+WAIT_CYCLES, ack at cycle A, rdy_ at A+1. Minimum strobe-to-rdy_ is 2 cycles.
- bus_cs_/bus_as_ while not IDLE: ignored, as the protocol allows only one outstanding transfer. A new strobe in the cycle after RESP is accepted.
- dev_ack outside DEV: ignored.
- Latched dev_* outputs hold their values until the next accepted strobe.

Decomposition:
- Add to bus.vh:
  - state encoding BusSlvStateBus: IDLE, WAIT, DEV, RESP (2 bits)
  - BUS_SLV_ERR_DATA default
- Reuse the stddef.vh ENABLE_/DISABLE_/READ/WRITE macros.
- Single module; the counters are inline and no sub-module is warranted.

Test Plan:
- Read, WAIT_CYCLES=0: strobe addr=0x10 at T, device acks at T+1 with 0x12345678 -> dev_req high T+1 only, bus_rdy_=0 at T+2 with bus_rd_data=0x12345678, 0 at T+3.
- Write, WAIT_CYCLES=3: strobe with wr_data=0xA5A5A5A5 -> dev_req rises at T+4 with dev_rw=WRITE and dev_wr_data=0xA5A5A5A5; ack at T+6 -> rdy_ at T+7, bus_rd_data=0.
- Timeout, TIMEOUT=4, no ack -> dev_req high for 4 cycles; then rdy_ plus timeout_err pulse together, with rd_data=0xDEADBEEF for a read.
- Ack in the same cycle as watchdog expiry -> device data returned, timeout_err stays 0.
- Strobe while in DEV, and strobe with bus_cs_=1 -> both ignored, latched address unchanged.
- Back-to-back transfers: new strobe in the cycle after rdy_ -> accepted.
- Reset asserted during WAIT -> next cycle IDLE, dev_req=0, no rdy_ pulse ever.
